fm_filter_sched: RTL and testbench

Single-clock scheduler for the FM audio decimation/low-pass chain. It replaces the ripple-divided stage clocks and per-stage clock crossings with one `clk_27m` domain. One shared filter-arithmetic unit is time-multiplexed across seven filter slots. Clock-enable decimation decides which slots run for each accepted input sample. It sits between the OPLL sample output and the audio mixer.

---
 rtl/fm_filter_pkg.sv | 13 +
 rtl/fm_filter_tap.sv | 28 ++
 rtl/fm_filter_sched.sv | 92 +++++++++
 tb/tb_fm_filter_sched.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fm_filter_pkg.sv
// fm_filter_pkg: shared constants, state and slot-kind types for the FM filter scheduler
package fm_filter_pkg;
  localparam int NUM_SLOTS = 7;
  localparam int MOD_A = 2;
  localparam int MOD_B = 5;
  localparam int MOD_C = 10;
  localparam logic [2:0] LAST_BASE = 3'd1;
  localparam logic [2:0] LAST_A = 3'd3;
  localparam logic [2:0] LAST_B = 3'd5;
  localparam logic [2:0] LAST_C = 3'd6;
  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic {TAP3, TAP2} kind_t;
endpackage

// File: rtl/fm_filter_tap.sv
// fm_filter_tap: shared filter arithmetic (3-tap binomial or 2-tap average), rounds half-up when FM_FILTER_SCHED_ROUND_EN is defined
module fm_filter_tap import fm_filter_pkg::*; #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] x1,
  input  logic [DATA_WIDTH-1:0] x2,
  input  kind_t                 kind,
  output logic [DATA_WIDTH-1:0] y
);
`ifdef FM_FILTER_SCHED_ROUND_EN
  localparam logic signed [DATA_WIDTH+1:0] RND3 = 2;
  localparam logic signed [DATA_WIDTH+1:0] RND2 = 1;
`else
  localparam logic signed [DATA_WIDTH+1:0] RND3 = 0;
  localparam logic signed [DATA_WIDTH+1:0] RND2 = 0;
`endif
  logic signed [DATA_WIDTH+1:0] xe, x1e, x2e, sum, shr;
  // two guard bits make the weighted sum overflow-free before the shift
  always_comb begin
    xe  = {{2{x[DATA_WIDTH-1]}}, x};
    x1e = {{2{x1[DATA_WIDTH-1]}}, x1};
    x2e = {{2{x2[DATA_WIDTH-1]}}, x2};
    sum = kind == TAP3 ? xe + (x1e <<< 1) + x2e + RND3 : xe + x1e + RND2;
    shr = kind == TAP3 ? sum >>> 2 : sum >>> 1;
    y   = shr[DATA_WIDTH-1:0];
  end
endmodule

// File: rtl/fm_filter_sched.sv
// fm_filter_sched: single-clock decimating filter scheduler, one shared tap across 7 slots; FM_FILTER_SCHED_ROUND_EN selects rounding
module fm_filter_sched import fm_filter_pkg::*; #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_27m,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  overrun
);
  state_t state, state_d;
  logic [2:0] slot, last;
  logic [DATA_WIDTH-1:0] cur, y;
  logic [DATA_WIDTH-1:0] hist1 [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] hist2 [NUM_SLOTS];
  logic cnt_a;
  logic [2:0] cnt_b;
  logic [3:0] cnt_c;
  logic accept, en_a, en_b, en_c;
  kind_t kind;

  assign busy     = state == RUN;
  assign in_ready = ~busy;
  assign accept   = in_valid & in_ready;
  assign en_a     = cnt_a == 1'(MOD_A - 1);
  assign en_b     = en_a & (cnt_b == 3'(MOD_B - 1));
  assign en_c     = en_b & (cnt_c == 4'(MOD_C - 1));
  assign kind     = slot == LAST_C ? TAP2 : TAP3;

  fm_filter_tap #(.DATA_WIDTH(DATA_WIDTH)) u_tap (
    .x   (cur),
    .x1  (hist1[slot]),
    .x2  (hist2[slot]),
    .kind(kind),
    .y   (y)
  );

  // next state: leave IDLE on acceptance, return right after the last enabled slot
  always_comb begin
    state_d = accept ? RUN : (busy && slot == last) ? IDLE : state;
  end

  // state register
  always_ff @(posedge clk_27m) begin
    if (!reset) state <= IDLE;
    else state <= state_d;
  end

  // pass setup, decimation counters, per-slot compute and output register
  always_ff @(posedge clk_27m) begin
    if (!reset) begin
      slot      <= '0;
      last      <= LAST_BASE;
      cur       <= '0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      cnt_c     <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        hist1[i] <= '0;
        hist2[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (in_valid && busy) overrun <= 1'b1;
      if (accept) begin
        cur   <= data_in;
        slot  <= '0;
        last  <= en_c ? LAST_C : en_b ? LAST_B : en_a ? LAST_A : LAST_BASE;
        cnt_a <= en_a ? 1'b0 : cnt_a + 1'b1;
        if (en_a) cnt_b <= en_b ? 3'd0 : cnt_b + 3'd1;
        if (en_b) cnt_c <= en_c ? 4'd0 : cnt_c + 4'd1;
      end
      if (busy) begin
        hist2[slot] <= hist1[slot];
        hist1[slot] <= cur;
        cur         <= y;
        slot        <= slot + 3'd1;
        if (slot == LAST_C) begin
          data_out  <= y;
          out_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fm_filter_sched.sv
// tb_fm_filter_sched: table, corner-case and random checks of fm_filter_sched against a slot-level reference model
module tb_fm_filter_sched;
  localparam int DW = 16;
`ifdef FM_FILTER_SCHED_ROUND_EN
  localparam int R3 = 2;
  localparam int R2 = 1;
`else
  localparam int R3 = 0;
  localparam int R2 = 0;
`endif
  typedef struct {int x; int n;} vec_t;

  logic clk_27m = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic in_ready, busy, out_valid, overrun;
  logic [DW-1:0] data_out;

  int checks = 0;
  int errors = 0;
  int mh1 [7];
  int mh2 [7];
  int mn, mdout, ov_total;

  fm_filter_sched #(.DATA_WIDTH(DW)) dut (
    .clk_27m  (clk_27m),
    .reset    (reset),
    .in_valid (in_valid),
    .data_in  (data_in),
    .in_ready (in_ready),
    .busy     (busy),
    .out_valid(out_valid),
    .data_out (data_out),
    .overrun  (overrun)
  );

  always #5 clk_27m = ~clk_27m;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 7; i++) begin
      mh1[i] = 0;
      mh2[i] = 0;
    end
    mn = 0;
    mdout = 0;
  endfunction

  // sample index mn decides which slots run: odd -> A, every 10th -> B, every 100th -> C
  function automatic void model_push(input int x, output int n, output bit ov);
    int v = x;
    int y, last;
    last = (mn % 100 == 99) ? 6 : (mn % 10 == 9) ? 5 : (mn % 2 == 1) ? 3 : 1;
    for (int s = 0; s <= last; s++) begin
      y = (s < 6) ? (v + 2 * mh1[s] + mh2[s] + R3) >>> 2 : (v + mh1[s] + R2) >>> 1;
      mh2[s] = mh1[s];
      mh1[s] = v;
      v = y;
    end
    mn++;
    n = last + 1;
    ov = (last == 6);
    if (ov) mdout = v;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    @(posedge clk_27m);
    #1 reset = 1'b1;
    model_reset();
  endtask

  // offer one sample, optionally poke in_valid during busy cycle drop_at, measure busy length and out_valid pulses
  task automatic push(input int x, input int drop_at, output int nb, output int nov);
    in_valid = 1'b1;
    data_in = x[DW-1:0];
    @(posedge clk_27m);
    #1 in_valid = 1'b0;
    nb = 0;
    nov = int'(out_valid);
    while (busy && nb < 20) begin
      in_valid = (drop_at != 0 && nb + 1 == drop_at);
      data_in = 16'h7fff;
      @(posedge clk_27m);
      #1 in_valid = 1'b0;
      nb++;
      nov += int'(out_valid);
    end
  endtask

  task automatic do_push(input int x, input int drop_at, output int nb);
    int nov, en;
    bit eov;
    push(x, drop_at, nb, nov);
    model_push(x, en, eov);
    ov_total += nov;
    chk("busy_len", nb, en);
    chk("out_valid", nov, eov ? 1 : 0);
    chk("data_out", $signed(data_out), mdout);
  endtask

  initial begin
    vec_t tbl [12];
    int nb, x;
    tbl[0] = '{16384, 2};
    for (int i = 1; i < 12; i++) tbl[i] = '{0, (i == 9) ? 6 : (i % 2 == 1) ? 4 : 2};
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", $signed(data_out), 0);
    chk("rst_overrun", overrun, 0);
    // impulse: busy lengths from a fixed table, values from the model
    for (int i = 0; i < 12; i++) begin
      do_push(tbl[i].x, 0, nb);
      chk("tbl_busy", nb, tbl[i].n);
    end
    for (int i = 12; i < 100; i++) do_push(0, 0, nb);
    chk("impulse_full_pass", nb, 7);
    // constant 1000 settles exactly, one output per 100 samples
    do_reset();
    ov_total = 0;
    for (int i = 0; i < 2000; i++) do_push(1000, 0, nb);
    chk("settle", $signed(data_out), 1000);
    chk("ov_count", ov_total, 20);
    // overrun in 3rd busy cycle of a full pass, then on the edge busy falls
    do_reset();
    for (int i = 0; i < 99; i++) do_push(int'($signed(DW'($urandom))), 0, nb);
    do_push(int'($signed(DW'($urandom))), 3, nb);
    chk("overrun_set", overrun, 1);
    do_push(1234, 2, nb);
    for (int i = 0; i < 99; i++) do_push(int'($signed(DW'($urandom))), 0, nb);
    chk("overrun_sticky", overrun, 1);
    chk("overrun_mn", mn, 200);
    // reset during slot 4 of a full pass
    for (int i = 0; i < 99; i++) do_push(int'($signed(DW'($urandom))), 0, nb);
    in_valid = 1'b1;
    data_in = 16'd500;
    @(posedge clk_27m);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk_27m);
    #1 reset = 1'b0;
    @(posedge clk_27m);
    #1 reset = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_data_out", $signed(data_out), 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_out_valid", out_valid, 0);
    model_reset();
    ov_total = 0;
    for (int i = 0; i < 2000; i++) do_push(1000, 0, nb);
    chk("restart_settle", $signed(data_out), 1000);
    chk("restart_ov_count", ov_total, 20);
    // random data and spacing, with +/-3 rounding probes mixed in
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      x = (i % 8 == 0) ? 3 : (i % 8 == 4) ? -3 : int'($signed(DW'($urandom)));
      do_push(x, 0, nb);
      repeat ($urandom_range(0, 4)) begin
        @(posedge clk_27m);
        #1;
      end
    end
    chk("random_no_overrun", overrun, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
